// File: rtl/cipher_pkg.sv
// cipher_pkg: shared types, constants and helper functions for the
// cipher round controller (ops, FSM states, rotations, round keys).
package cipher_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD_LO = 2'b00,
    OP_LOAD_HI = 2'b01,
    OP_ENC     = 2'b10,
    OP_DEC     = 2'b11
  } op_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int ROUNDS_DEFAULT = 8;
  localparam int KEY_W_DEFAULT  = 16;

  // Width of the round index: clog2(rounds), never less than one bit.
  function automatic int idx_width(input int rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

  function automatic logic [7:0] rotl3(input logic [7:0] v);
    return {v[4:0], v[7:5]};
  endfunction

  function automatic logic [7:0] rotr3(input logic [7:0] v);
    return {v[2:0], v[7:3]};
  endfunction

  // Round key i: low byte of the 16-bit key rotated left by 2*i (mod 16).
  function automatic logic [7:0] round_key(input logic [15:0] key,
                                           input logic [3:0]  i);
    logic [3:0]  sh;
    logic [31:0] dbl;
    sh  = {i[2:0], 1'b0};
    dbl = {key, key} << sh;
    return dbl[23:16];
  endfunction

endpackage

// File: rtl/cipher_round_ctrl_if.sv
// cipher_round_ctrl_if: command and result valid/ready channels between
// the pin-level shim (master) and the round controller (slave).
interface cipher_round_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/cipher_round.sv
// cipher_round: one combinational cipher round, shared by encrypt
// (mode=0) and decrypt (mode=1).
module cipher_round
  import cipher_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             mode,
  input  logic [7:0]       s,
  input  logic [7:0]       rk,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       s_next
);

  logic [7:0] idx8;
  assign idx8 = 8'(idx);

  // Encrypt: rotl3(s ^ rk) + i.  Decrypt undoes it: rotr3(s - i) ^ rk.
  // NOTE: every branch assigns s_next, so no latch is inferred.
  always_comb begin
    if (!mode) s_next = rotl3(s ^ rk) + idx8;
    else       s_next = rotr3(s - idx8) ^ rk;
  end

endmodule

// File: rtl/cipher_round_ctrl.sv
// cipher_round_ctrl: iterative round sequencer for the 8-bit block cipher.
// Accepts key loads and encrypt/decrypt commands in IDLE, runs ROUNDS
// rounds through one shared cipher_round, then holds the result until
// it is taken. Define CIPHER_CTRL_ABORT_EN to add the abort input.
module cipher_round_ctrl
  import cipher_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int KEY_W  = KEY_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
`ifdef CIPHER_CTRL_ABORT_EN
  input  logic abort,
`endif
  cipher_round_ctrl_if.slave bus,
  output logic busy
);

  localparam int               IDX_W    = idx_width(ROUNDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);

  state_e           state;
  logic [KEY_W-1:0] key;
  logic [7:0]       s;
  logic [IDX_W-1:0] idx;
  logic             mode;   // 0 = encrypt, 1 = decrypt
  logic [7:0]       s_next;
  logic [7:0]       rk;
  logic             last_round;

  assign rk         = round_key(key[15:0], 4'(idx));
  assign last_round = (idx == (mode ? '0 : IDX_LAST));

  cipher_round #(.IDX_W(IDX_W)) u_round (
    .mode   (mode),
    .s      (s),
    .rk     (rk),
    .idx    (idx),
    .s_next (s_next)
  );

  // Outputs are decoded from state and registers only.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == HOLD);
  assign bus.res_data  = s;
  assign busy          = (state != IDLE);

  // Controller FSM: command intake, round sequencing, result hold.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key   <= '0;
      s     <= '0;
      idx   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_LOAD_LO: key[7:0]  <= bus.cmd_data;
              OP_LOAD_HI: key[15:8] <= bus.cmd_data;
              OP_ENC: begin
                s     <= bus.cmd_data;
                mode  <= 1'b0;
                idx   <= '0;
                state <= RUN;
              end
              OP_DEC: begin
                s     <= bus.cmd_data;
                mode  <= 1'b1;
                idx   <= IDX_LAST;
                state <= RUN;
              end
            endcase
          end
        end
        RUN: begin
          s <= s_next;
          if (last_round) state <= HOLD;
          else if (mode)  idx   <= idx - IDX_W'(1);
          else            idx   <= idx + IDX_W'(1);
        end
        HOLD: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CIPHER_CTRL_ABORT_EN
      // Abort overrides the HOLD handshake; the key is left untouched.
      if (abort && state != IDLE) state <= IDLE;
`endif
    end
  end

endmodule

// File: doc/cipher_round_ctrl.md
# cipher_round_ctrl

Iterative round sequencer for the 8-bit block cipher in `tt_um_Sai222777`. It accepts key-load and encrypt/decrypt commands over a valid/ready port and holds the 16-bit key. It drives one shared round unit for ROUNDS cycles per block, then presents the result on a valid/ready output. It sits between the pin-level I/O shim and the round datapath.

## Interface
- `ROUNDS`, 8: rounds per block; legal range 1..16.
- `KEY_W`, 16: key width; fixed at 16 in this revision.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller accepts a command; high only in IDLE.
- `cmd_op`  in  2  command: 00 LOAD_KEY_LO, 01 LOAD_KEY_HI, 10 ENCRYPT, 11 DECRYPT.
- `cmd_data`  in  8  key byte or data block.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  8  result block.
- `busy`  out  1  high in RUN or HOLD.

## Operation
- Key register `key[15:0]` = {hi, lo}.
- Round key: `rk_i = (key rotl 2*i)[7:0]`, rotation over 16 bits.
- Encrypt round i, i = 0..ROUNDS-1 ascending: `s = rotl3(s ^ rk_i) + i`, addition mod 256, i zero-extended.
- Decrypt round i, i = ROUNDS-1..0 descending: `s = rotr3(s - i) ^ rk_i`, subtraction mod 256. Decrypt is the exact inverse of encrypt.
- FSM:
  - IDLE: `cmd_ready`=1.
    - LOAD_KEY_LO/HI on handshake: write the key byte, stay in IDLE.
    - ENCRYPT/DECRYPT on handshake: load `s`=`cmd_data`, latch mode, set `idx` to 0 (encrypt) or ROUNDS-1 (decrypt), go to RUN.
  - RUN: one round per cycle. `idx` increments (encrypt) or decrements (decrypt). After the ROUNDS-th round, go to HOLD.
  - HOLD: `res_valid`=1, `res_data`=`s`, both stable. Return to IDLE on the edge where `res_ready`=1.
- `idx` width is `$clog2(ROUNDS)`, minimum 1. No wrap occurs: the round count is tracked by `idx` reaching its terminal value, 0 or ROUNDS-1.
- `cmd_valid` in RUN or HOLD is ignored. The command is not consumed; the master must hold it.
- A key load applies only to blocks accepted afterwards, because loads are accepted only in IDLE.

## Timing
- Reset values: state IDLE, `key`=0x0000, `s`=0, `idx`=0, `cmd_ready`=1, `res_valid`=0, `res_data`=0x00, `busy`=0.
- A synchronous `rst` in any state, including mid-RUN or HOLD, returns to the reset values on the next edge. Any in-flight block is discarded.
- Latency: block accepted at edge E0; rounds applied at edges E1..E_ROUNDS; `res_valid` high from E_ROUNDS onward.
- Result handshake at edge Eh: `res_valid` low and `cmd_ready` high after Eh. There is no same-cycle bypass into a new command.
- Key load throughput: one per cycle with `cmd_ready` held high.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `CIPHER_CTRL_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort`=1 in RUN or HOLD returns to IDLE at the next edge, drops the result, and clears `res_valid`.
  - `abort` in IDLE has no effect, and `abort` has priority over `res_ready`.
  - `key` is preserved.
- Not defined: the `abort` port is absent and blocks always complete.

## Structure
- `cipher_pkg` holds:
  - the op enum (`OP_LOAD_LO`, `OP_LOAD_HI`, `OP_ENC`, `OP_DEC`);
  - the FSM state enum (IDLE, RUN, HOLD);
  - the default round count constant;
  - the `rotl3`/`rotr3` and round-key functions.
- Sub-module `cipher_round`: purely combinational, inputs `mode`, `s`, `rk`, `idx`, output next `s`. It is shared by encrypt and decrypt and instantiated once.

## Test plan
- Reset: assert `rst` 2 cycles → `cmd_ready`=1, `res_valid`=0, `busy`=0, `res_data`=0x00.
- Key 0x0000, ENCRYPT 0x00, ROUNDS=8 → `res_valid` rises exactly 8 edges after acceptance, `res_data`=0xB5.
- Key 0x0000, DECRYPT 0xB5 → `res_data`=0x00. With key 0xA5C3, 64 random blocks satisfy encrypt→decrypt round-trip equality.
- Backpressure: hold `res_ready`=0 for 5 cycles in HOLD while `cmd_valid`=1 → `res_data` stable, `cmd_ready`=0, no command consumed. Then `res_ready`=1 → IDLE next cycle, pending command accepted the cycle after.
- Assert `rst` at round 4 of RUN → the next cycle matches reset values, including `key`=0x0000, and no `res_valid` pulse appears.
- With `CIPHER_CTRL_ABORT_EN`: `abort` during RUN → IDLE next edge, `res_valid` never asserts, and a following ENCRYPT uses the retained key.
